// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: merges load and ALU results into one write port in order.
// Optional macro RF_WB_FWD_EN compiles in forwarding lookups over pending writes.
module rf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [2:0]               alu_rd,
   input  logic [15:0]              alu_data,
   output logic                     alu_ready,
   input  logic                     ld_valid,
   input  logic [2:0]               ld_rd,
   input  logic [15:0]              ld_data,
   output logic                     ld_ready,
   input  logic                     wb_stall,
   output logic                     we,
   output logic [2:0]               ws,
   output logic [15:0]              wd,
   input  logic [2:0]               q1_rs,
   input  logic [2:0]               q2_rs,
   output logic                     q1_hit,
   output logic [15:0]              q1_data,
   output logic                     q2_hit,
   output logic [15:0]              q2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [2:0]    r_rd   [DEPTH];
   logic [15:0]   r_data [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_we;
   logic [2:0]    r_ws;
   logic [15:0]   r_wd;

   logic          w_full;
   logic          w_empty;
   logic          w_enq;
   logic          w_pop;
   logic [2:0]    w_enq_rd;
   logic [15:0]   w_enq_data;

   // Status is forced to the idle view while reset is held, before the first reset edge lands.
   assign w_full     = reset & (r_count == C_DEPTH);
   assign w_empty    = ~reset | (r_count == {CW{1'b0}});
   assign ld_ready   = ~w_full;
   assign alu_ready  = ~w_full & ~ld_valid;
   assign w_enq      = reset & ((ld_valid & ld_ready) | (alu_valid & alu_ready));
   assign w_enq_rd   = ld_valid ? ld_rd : alu_rd;
   assign w_enq_data = ld_valid ? ld_data : alu_data;
   assign w_pop      = ~w_empty & ~wb_stall;

   assign full  = w_full;
   assign empty = w_empty;
   assign count = r_count;
   assign we    = r_we;
   assign ws    = r_ws;
   assign wd    = r_wd;

   // Entry storage; contents are only meaningful inside the rptr..wptr window.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_rd[r_wptr]   <= w_enq_rd;
         r_data[r_wptr] <= w_enq_data;
      end
   end

   // Pointers, occupancy and the registered write port.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wptr  <= {PW{1'b0}};
         r_rptr  <= {PW{1'b0}};
         r_count <= {CW{1'b0}};
         r_we    <= 1'b0;
         r_ws    <= 3'd0;
         r_wd    <= 16'h0000;
      end else begin
         r_we <= w_pop;
         if (w_enq) begin
            r_wptr <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rptr <= r_rptr + {{(PW-1){1'b0}}, 1'b1};
            r_ws   <= r_rd[r_rptr];
            r_wd   <= r_data[r_rptr];
         end
         case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef RF_WB_FWD_EN
   // Candidates scanned oldest first (output stage, then queue head onward); the last match wins.
   always_comb begin
      logic w_m1;
      logic w_m2;
      q1_hit  = 1'b0;
      q1_data = 16'h0000;
      q2_hit  = 1'b0;
      q2_data = 16'h0000;
      w_m1    = reset & r_we & (r_ws == q1_rs);
      w_m2    = reset & r_we & (r_ws == q2_rs);
      q1_hit  = w_m1;
      q1_data = w_m1 ? r_wd : 16'h0000;
      q2_hit  = w_m2;
      q2_data = w_m2 ? r_wd : 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
         w_m1    = reset & (CW'(i) < r_count) & (r_rd[r_rptr + PW'(i)] == q1_rs);
         w_m2    = reset & (CW'(i) < r_count) & (r_rd[r_rptr + PW'(i)] == q2_rs);
         q1_hit  = q1_hit | w_m1;
         q1_data = w_m1 ? r_data[r_rptr + PW'(i)] : q1_data;
         q2_hit  = q2_hit | w_m2;
         q2_data = w_m2 ? r_data[r_rptr + PW'(i)] : q2_data;
      end
   end
`else
   logic w_unused_rs;
   assign w_unused_rs = ^{q1_rs, q2_rs};
   assign q1_hit  = 1'b0;
   assign q1_data = 16'h0000;
   assign q2_hit  = 1'b0;
   assign q2_data = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios plus random traffic
// compared against a queue-based reference model of the writeback rules.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, ld_valid, wb_stall;
   logic [2:0]  alu_rd, ld_rd, q1_rs, q2_rs;
   logic [15:0] alu_data, ld_data;
   logic        alu_ready, ld_ready, we, q1_hit, q2_hit, full, empty;
   logic [2:0]  ws;
   logic [15:0] wd, q1_data, q2_data;
   logic [$clog2(DEPTH):0] count;

   always #5 clk = ~clk;

   rf_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .wb_stall(wb_stall), .we(we), .ws(ws), .wd(wd),
      .q1_rs(q1_rs), .q2_rs(q2_rs),
      .q1_hit(q1_hit), .q1_data(q1_data), .q2_hit(q2_hit), .q2_data(q2_data),
      .count(count), .full(full), .empty(empty)
   );

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] data;
   } ent_t;

   ent_t        mq[$];
   logic        m_we = 1'b0;
   logic [2:0]  m_ws = 3'd0;
   logic [15:0] m_wd = 16'h0000;
   int          n_assert = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pending-write lookup: output stage is oldest, queue back is newest; newest match wins.
   task automatic ref_fwd(input logic [2:0] rs, output logic hit, output logic [15:0] d);
      hit = 1'b0;
      d   = 16'h0000;
`ifdef RF_WB_FWD_EN
      if (reset) begin
         if (m_we && m_ws == rs) begin
            hit = 1'b1;
            d   = m_wd;
         end
         foreach (mq[i]) begin
            if (mq[i].rd == rs) begin
               hit = 1'b1;
               d   = mq[i].data;
            end
         end
      end
`endif
   endtask

   // One clock: check combinational view, advance model at the edge, check registered port.
   task automatic cycle();
      int          sz;
      logic        h;
      logic [15:0] d;
      ent_t        e;
      #1;
      sz = mq.size();
      check("count", 32'(count), 32'(sz));
      check("empty", 32'(empty), 32'(!reset || sz == 0));
      check("full", 32'(full), 32'(reset && sz == DEPTH));
      check("ld_ready", 32'(ld_ready), 32'(!(reset && sz == DEPTH)));
      check("alu_ready", 32'(alu_ready), 32'(!(reset && sz == DEPTH) && !ld_valid));
      ref_fwd(q1_rs, h, d);
      check("q1_hit", 32'(q1_hit), 32'(h));
      check("q1_data", 32'(q1_data), 32'(d));
      ref_fwd(q2_rs, h, d);
      check("q2_hit", 32'(q2_hit), 32'(h));
      check("q2_data", 32'(q2_data), 32'(d));
      @(posedge clk);
      if (!reset) begin
         mq.delete();
         m_we = 1'b0;
         m_ws = 3'd0;
         m_wd = 16'h0000;
      end else begin
         if (sz > 0 && !wb_stall) begin
            e    = mq.pop_front();
            m_we = 1'b1;
            m_ws = e.rd;
            m_wd = e.data;
         end else begin
            m_we = 1'b0;
         end
         if (sz != DEPTH) begin
            if (ld_valid) begin
               e.rd = ld_rd; e.data = ld_data; mq.push_back(e);
            end else if (alu_valid) begin
               e.rd = alu_rd; e.data = alu_data; mq.push_back(e);
            end
         end
      end
      @(negedge clk);
      check("we", 32'(we), 32'(m_we));
      check("ws", 32'(ws), 32'(m_ws));
      check("wd", 32'(wd), 32'(m_wd));
   endtask

   initial begin
      reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; wb_stall = 1'b0;
      alu_rd = 3'd0; ld_rd = 3'd0; alu_data = 16'h0; ld_data = 16'h0;
      q1_rs = 3'd0; q2_rs = 3'd0;
      @(negedge clk);
      cycle();
      cycle();
      check("rst_count", 32'(count), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      reset = 1'b1;

      // Single ALU result flows straight through.
      alu_valid = 1'b1; alu_rd = 3'd3; alu_data = 16'h1234; q1_rs = 3'd3;
      cycle();
      alu_valid = 1'b0;
      cycle();
      check("alu_we", 32'(we), 32'd1);
      check("alu_ws", 32'(ws), 32'd3);
      check("alu_wd", 32'(wd), 32'h1234);
      cycle();
      check("alu_we_off", 32'(we), 32'd0);
      check("alu_cnt0", 32'(count), 32'd0);

      // Load beats ALU; ALU is held one more cycle.
      ld_valid = 1'b1; ld_rd = 3'd1; ld_data = 16'hAAAA;
      alu_valid = 1'b1; alu_rd = 3'd2; alu_data = 16'h5555;
      #1 check("prio_alu_rdy", 32'(alu_ready), 32'd0);
      cycle();
      ld_valid = 1'b0;
      cycle();
      check("prio_ws1", 32'(ws), 32'd1);
      alu_valid = 1'b0;
      cycle();
      check("prio_ws2", 32'(ws), 32'd2);
      check("prio_wd2", 32'(wd), 32'h5555);
      cycle();

      // Stalled fill with five offers; fifth waits until a slot opens.
      wb_stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         alu_valid = 1'b1; alu_rd = 3'(k); alu_data = 16'h0100 + 16'(k);
         cycle();
      end
      check("fill_full", 32'(full), 32'd1);
      check("fill_cnt", 32'(count), 32'd4);
      check("fill_alu_rdy", 32'(alu_ready), 32'd0);
      wb_stall = 1'b0;
      cycle();
      check("rel_cnt3", 32'(count), 32'd3);
      cycle();
      alu_valid = 1'b0;
      for (int k = 0; k < 6; k++) cycle();
      check("drain_ws4", 32'(ws), 32'd4);

      // Full queue, one-cycle release with ALU held: count goes 4,3,4.
      wb_stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         alu_valid = 1'b1; alu_rd = 3'(k + 4); alu_data = 16'h0200 + 16'(k);
         cycle();
      end
      alu_rd = 3'd7; alu_data = 16'h0BEE;
      check("seq_c4", 32'(count), 32'd4);
      wb_stall = 1'b0;
      cycle();
      check("seq_c3", 32'(count), 32'd3);
      wb_stall = 1'b1;
      cycle();
      check("seq_c4b", 32'(count), 32'd4);
      alu_valid = 1'b0;
      wb_stall = 1'b0;
      for (int k = 0; k < 6; k++) cycle();

      // Two pending writes to R5: newest value must be forwarded.
      wb_stall = 1'b1;
      alu_valid = 1'b1; alu_rd = 3'd5; alu_data = 16'h0001;
      cycle();
      alu_data = 16'h0002;
      cycle();
      alu_valid = 1'b0; q1_rs = 3'd5; q2_rs = 3'd6;
      #1;
`ifdef RF_WB_FWD_EN
      check("fwd_hit", 32'(q1_hit), 32'd1);
      check("fwd_data", 32'(q1_data), 32'h0002);
`else
      check("fwd_hit", 32'(q1_hit), 32'd0);
      check("fwd_data", 32'(q1_data), 32'h0000);
`endif
      check("fwd_miss", 32'(q2_hit), 32'd0);

      // Third entry, then reset discards all three.
      alu_valid = 1'b1; alu_rd = 3'd0; alu_data = 16'h0003;
      cycle();
      alu_valid = 1'b0;
      check("pre_rst_cnt", 32'(count), 32'd3);
      reset = 1'b0;
      cycle();
      check("mid_rst_cnt", 32'(count), 32'd0);
      check("mid_rst_we", 32'(we), 32'd0);
      reset = 1'b1; wb_stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("post_rst_we", 32'(we), 32'd0);
      end

      // Random traffic against the reference model.
      for (int k = 0; k < 600; k++) begin
         reset     = ($urandom_range(0, 59) != 0);
         ld_valid  = ($urandom_range(0, 2) == 0);
         alu_valid = ($urandom_range(0, 1) == 0);
         wb_stall  = ($urandom_range(0, 2) == 0);
         ld_rd     = 3'($urandom); ld_data = 16'($urandom);
         alu_rd    = 3'($urandom); alu_data = 16'($urandom);
         q1_rs     = 3'($urandom); q2_rs = 3'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wb_queue.md
RF_WB_QUEUE -- requirements
Module: rf_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of writeback queue entries; legal values are powers of two, 2..16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 alu_valid/alu_rd/alu_data  input  1/3/16  ALU result offer: valid flag, destination register index, result value.
REQ-005 alu_ready  output  1  ALU offer is accepted at this edge.
REQ-006 ld_valid/ld_rd/ld_data  input  1/3/16  load result offer: valid flag, destination register index, loaded value.
REQ-007 ld_ready  output  1  load offer is accepted at this edge.
REQ-008 wb_stall  input  1  holds the queue head; no pop while high.
REQ-009 we/ws/wd  output  1/3/16  register-file write port (write enable, register index, write data); registered.
REQ-010 q1_rs/q2_rs  input  3/3  forwarding lookup register indices.
REQ-011 q1_hit/q1_data, q2_hit/q2_data  output  1/16 each  forwarding result: pending write found, and its value.
REQ-012 count  output  $clog2(DEPTH)+1  occupied entries; full/empty  output  1/1  count==DEPTH / count==0.

Function
- REQ-013 Circular FIFO: write pointer, read pointer, count; pointers wrap modulo DEPTH.
- REQ-014 At most one enqueue per cycle; load has priority over ALU.
- REQ-015 ld_ready = !full; alu_ready = !full && !ld_valid (combinational from registered count).
- REQ-016 Enqueue occurs at an edge when the selected source's valid and ready are both high.
- REQ-017 No enqueue while full, even if a pop occurs in the same cycle.
- REQ-018 Pop occurs at an edge when !empty && !wb_stall; at that edge we<=1, ws<=head.rd, wd<=head.data.
- REQ-019 Otherwise we<=0 at the edge; ws/wd hold their last values.
- REQ-020 Latency: an entry enqueued into an empty queue at edge N with wb_stall low pops at edge N+1, so we is high during cycle N+1..N+2.
- REQ-021 Simultaneous enqueue and pop leaves count unchanged; enqueue alone adds 1; pop alone subtracts 1.
- REQ-022 Writes are issued strictly in enqueue order.
- REQ-023 R0 receives no special treatment; writes to R0 are issued like any other register.
- REQ-024 Forwarding is combinational over valid queue entries plus the output stage (when we=1).
- REQ-025 For each query, hit=1 if any candidate's rd equals the query index; data is taken from the newest match (output stage is the oldest candidate).
- REQ-026 For each query, no match gives hit=0 and data=16'h0000.
- REQ-027 A same-cycle incoming offer is not visible to forwarding until it is enqueued.

Reset
- REQ-028 While reset=0 at an edge: pointers=0, count=0, we=0, ws=3'd0, wd=16'h0000.
- REQ-029 Reset mid-operation discards all pending entries without issuing writes.
- REQ-030 During reset, empty=1, full=0, all hits=0, ld_ready=1, and alu_ready=!ld_valid.

Configuration
- REQ-031 Macro RF_WB_FWD_EN, when defined, compiles in the forwarding logic of REQ-024..REQ-027.
- REQ-032 When RF_WB_FWD_EN is undefined, q1_hit=q2_hit=0 and q1_data=q2_data=16'h0000 constantly; q1_rs/q2_rs are ignored.

Verification
- REQ-033 Reset, then alu_valid=1, alu_rd=3, alu_data=16'h1234 for one cycle -> next cycle we=1, ws=3, wd=16'h1234 for exactly one cycle; count returns to 0.
- REQ-034 ld_valid and alu_valid high together (ld_rd=1/16'hAAAA, alu_rd=2/16'h5555) -> ld accepted and alu_ready=0; alu held one cycle more -> writes issued R1 then R2.
- REQ-035 wb_stall=1 with 5 offers at DEPTH=4 -> 4 accepted; full=1; ld_ready=alu_ready=0; on release, 4 writes in order, then the 5th after it is accepted.
- REQ-036 Queue holds R5=16'h0001 then R5=16'h0002, stalled; q1_rs=5 -> with macro: q1_hit=1, q1_data=16'h0002; without macro: hit=0, data=0.
- REQ-037 Three entries pending, reset=0 for one edge -> count=0, we=0; no further writes issued.
- REQ-038 Full queue, stall released with alu_valid held -> no accept on the pop edge; accept on the following edge; count sequence 4,3,4.
